// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
// Bundles the common-data-bus request/grant handshake and the registered
// broadcast between the functional units and the CDB arbiter.
// The optional performance counters appear only when CDB_ARB_PERF_EN is
// defined; the default build carries just the handshake and broadcast.
interface cdb_arbiter_if #(
    parameter int NFU = 4,
    parameter int IDW = 4,
    parameter int DW  = 8
);

    // Functional-unit side: request, tag and value held until granted
    logic [NFU-1:0]           req;
    logic [NFU-1:0][IDW-1:0]  req_id;
    logic [NFU-1:0][DW-1:0]   req_val;

    // Consumer back-pressure
    logic                     hold;

    // Arbiter side: one-hot grant and the registered broadcast
    logic [NFU-1:0]           grant;
    logic                     cdb_valid;
    logic [IDW-1:0]           cdb_id;
    logic [DW-1:0]            cdb_val;

`ifdef CDB_ARB_PERF_EN
    // Saturating per-FU grant counters and contended-cycle counter
    logic [NFU-1:0][15:0]     grant_cnt;
    logic [15:0]              conflict_cnt;
`endif

    // Functional units and consumers drive requests/hold and observe grants
    modport master (
        output req, req_id, req_val, hold,
        input  grant, cdb_valid, cdb_id, cdb_val
`ifdef CDB_ARB_PERF_EN
        , input grant_cnt, conflict_cnt
`endif
    );

    // The arbiter consumes requests/hold and produces grants and the broadcast
    modport slave (
        input  req, req_id, req_val, hold,
        output grant, cdb_valid, cdb_id, cdb_val
`ifdef CDB_ARB_PERF_EN
        , output grant_cnt, conflict_cnt
`endif
    );

endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Round-robin arbiter for the single common-data-bus broadcast port.
// Up to NFU functional units request the bus; at most one is granted per
// cycle (combinational one-hot grant) and its tag/value is broadcast on the
// following cycle from registers.
// Optional feature macro: CDB_ARB_PERF_EN adds saturating 16-bit grant and
// conflict counters; arbitration is identical with or without it.
module cdb_arbiter #(
    parameter int NFU = 4,
    parameter int IDW = 4,
    parameter int DW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    // Pointer wide enough to name every FU index
    localparam int PW = (NFU > 1) ? $clog2(NFU) : 1;

    // Round-robin pointer: the FU index searched first this cycle
    logic [PW-1:0]   r_ptr;

    // Registered broadcast toward reservation stations and rename logic
    logic            r_cdbValid;
    logic [IDW-1:0]  r_cdbId;
    logic [DW-1:0]   r_cdbVal;

    // Arbitration result for the current cycle
    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic            w_grantEn;
    logic [NFU-1:0]  w_grant;
    logic [PW-1:0]   w_nextPtr;

    // Rotating priority search: start at r_ptr, wrap modulo NFU and take the
    // first asserted request. Only req and the pointer feed this path, so the
    // data value never reaches the grant timing path.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NFU; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % NFU]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_ptr) + k) % NFU);
            end
        end
    end

    // A grant happens only with a winner, consumers not stalled, and reset
    // released; reset forces the grant low even before the first clock edge
    assign w_grantEn = w_found & ~bus.hold & ~rst;

    // Decode the winning index into the one-hot grant vector
    always_comb begin
        w_grant = '0;
        if (w_grantEn) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    // Next search start is one past the winner, wrapping explicitly so that
    // non-power-of-two NFU values never land on an unused index
    assign w_nextPtr = (w_winner == PW'(NFU - 1)) ? '0 : (w_winner + 1'b1);

    // Capture the winner's tag/value for a one-cycle broadcast and advance the
    // pointer; idle or held cycles drop valid but keep the last tag/value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_cdbValid <= 1'b0;
            r_cdbId    <= '0;
            r_cdbVal   <= '0;
        end else if (w_grantEn) begin
            r_ptr      <= w_nextPtr;
            r_cdbValid <= 1'b1;
            r_cdbId    <= bus.req_id[w_winner];
            r_cdbVal   <= bus.req_val[w_winner];
        end else begin
            r_cdbValid <= 1'b0;
        end
    end

    assign bus.grant     = w_grant;
    assign bus.cdb_valid = r_cdbValid;
    assign bus.cdb_id    = r_cdbId;
    assign bus.cdb_val   = r_cdbVal;

`ifdef CDB_ARB_PERF_EN
    logic [NFU-1:0][15:0] r_grantCnt;
    logic [15:0]          r_conflictCnt;
    logic                 w_contended;

    // A cycle is contended when two or more FUs want the bus at once
    assign w_contended = ($countones(bus.req) > 1);

    // Saturating counters: grants per FU and granted cycles under contention;
    // only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grantCnt    <= '0;
            r_conflictCnt <= '0;
        end else begin
            for (int i = 0; i < NFU; i++) begin
                if (w_grant[i] && (r_grantCnt[i] != 16'hFFFF)) begin
                    r_grantCnt[i] <= r_grantCnt[i] + 16'd1;
                end
            end
            if (w_grantEn && w_contended && (r_conflictCnt != 16'hFFFF)) begin
                r_conflictCnt <= r_conflictCnt + 16'd1;
            end
        end
    end

    assign bus.grant_cnt    = r_grantCnt;
    assign bus.conflict_cnt = r_conflictCnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Directed bench for cdb_arbiter with NFU=4, IDW=4, DW=8. A vector table
// covers round-robin rotation, wrap/skip, hold and single-requester
// streaming; hand-written sequences cover reset mid-broadcast and, when
// CDB_ARB_PERF_EN is defined, the counters including saturation.
module tb_cdb_arbiter;

    logic clk;
    logic rst;

    int assertCount;
    int failCount;

    cdb_arbiter_if #(.NFU(4), .IDW(4), .DW(8)) bus ();

    cdb_arbiter #(.NFU(4), .IDW(4), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [3:0] expGrant;
        logic       expValid;
        logic [3:0] expId;
        logic [7:0] expVal;
    } vec_t;

    vec_t vecs [22];

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of requests on the falling edge, settle, then return
    task automatic applyStimulus(input logic [3:0] req, input logic hold);
        @(negedge clk);
        bus.req  = req;
        bus.hold = hold;
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Fixed per-FU tags and values (FU3 .. FU0)
        bus.req_id  = {4'hC, 4'h7, 4'hA, 4'h3};
        bus.req_val = {8'hF1, 8'h2E, 8'h5C, 8'h10};
        bus.req     = 4'b0000;
        bus.hold    = 1'b0;
        rst         = 1'b1;

        //            req      hold  grant    vld   id     val
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 4'h0, 8'h00};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 4'h3, 8'h10};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 4'hA, 8'h5C};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 4'h7, 8'h2E};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 4'hC, 8'hF1};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 4'h3, 8'h10};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 4'hA, 8'h5C};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 4'h7, 8'h2E};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'hC, 8'hF1};
        vecs[9]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 4'h7, 8'h2E};
        vecs[10] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 4'h3, 8'h10};
        vecs[11] = '{4'b0010, 1'b1, 4'b0000, 1'b1, 4'h7, 8'h2E};
        vecs[12] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 4'h7, 8'h2E};
        vecs[13] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 4'h7, 8'h2E};
        vecs[14] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'h7, 8'h2E};
        vecs[15] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'hA, 8'h5C};
        vecs[16] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'hC, 8'hF1};
        vecs[17] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'hC, 8'hF1};
        vecs[18] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'hC, 8'hF1};
        vecs[19] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'hC, 8'hF1};
        vecs[20] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'hC, 8'hF1};
        vecs[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'hC, 8'hF1};

        // Reset state, including grant held low while requests are present
        repeat (2) @(negedge clk);
        bus.req = 4'b1111;
        #1;
        checkOutput("reset grant", 32'(bus.grant), 32'h0);
        checkOutput("reset valid", 32'(bus.cdb_valid), 32'h0);
        checkOutput("reset id", 32'(bus.cdb_id), 32'h0);
        checkOutput("reset val", 32'(bus.cdb_val), 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 4'b0000;

        // Table: rotation, wrap/skip from ptr=3, hold, streaming, idle
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].req, vecs[i].hold);
            checkOutput($sformatf("vec%0d grant", i), 32'(bus.grant), 32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d valid", i), 32'(bus.cdb_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d id", i), 32'(bus.cdb_id), 32'(vecs[i].expId));
            checkOutput($sformatf("vec%0d val", i), 32'(bus.cdb_val), 32'(vecs[i].expVal));
        end

        // Reset mid-broadcast: grant FU1 (pointer moves to 2), then reset
        // while its broadcast is visible
        applyStimulus(4'b0010, 1'b0);
        checkOutput("pre-reset grant", 32'(bus.grant), 32'b0010);
        @(negedge clk);
        bus.req = 4'b0000;
        #1;
        checkOutput("pre-reset valid", 32'(bus.cdb_valid), 32'h1);
        checkOutput("pre-reset id", 32'(bus.cdb_id), 32'hA);
        rst     = 1'b1;
        bus.req = 4'b1111;
        #1;
        checkOutput("midreset valid", 32'(bus.cdb_valid), 32'h0);
        checkOutput("midreset id", 32'(bus.cdb_id), 32'h0);
        checkOutput("midreset val", 32'(bus.cdb_val), 32'h0);
        checkOutput("midreset grant", 32'(bus.grant), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-reset grant", 32'(bus.grant), 32'b0001);
        @(negedge clk);
        #1;
        checkOutput("post-reset valid", 32'(bus.cdb_valid), 32'h1);
        checkOutput("post-reset id", 32'(bus.cdb_id), 32'h3);

`ifdef CDB_ARB_PERF_EN
        // Counters: clear by reset, then six contended cycles on FUs 0 and 1
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 4'b0000;
        #1;
        checkOutput("perf reset gcnt0", 32'(bus.grant_cnt[0]), 32'h0);
        checkOutput("perf reset conflict", 32'(bus.conflict_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b0011, 1'b0);
            checkOutput($sformatf("perf grant%0d", c), 32'(bus.grant),
                        (c % 2 == 0) ? 32'b0001 : 32'b0010);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("perf gcnt0", 32'(bus.grant_cnt[0]), 32'd3);
        checkOutput("perf gcnt1", 32'(bus.grant_cnt[1]), 32'd3);
        checkOutput("perf gcnt2", 32'(bus.grant_cnt[2]), 32'd0);
        checkOutput("perf conflict", 32'(bus.conflict_cnt), 32'd6);

        // Saturation: preload the conflict counter, grant once more
        @(negedge clk);
        force dut.r_conflictCnt = 16'hFFFF;
        #1;
        release dut.r_conflictCnt;
        bus.req = 4'b0011;
        @(negedge clk);
        bus.req = 4'b0000;
        #1;
        checkOutput("perf conflict sat", 32'(bus.conflict_cnt), 32'hFFFF);
        checkOutput("perf gcnt0 after sat", 32'(bus.grant_cnt[0]), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB). Shares the single CDB broadcast port among up to `NFU` functional units (ALU, load/store, branch). Each FU raises its CDB request and holds its tag/value until it sees its CDB grant. The arbiter grants at most one FU per cycle and drives a registered one-cycle broadcast to the reservation stations and register rename logic.

## Interface
Parameters:
- `NFU`, 4: number of requesting functional units (2..8).
- `IDW`, 4: ROB tag width.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  NFU  per-FU CDB request (FU's `cdb_transmit_out`).
- `req_id`  in  NFU x IDW  per-FU ROB tag.
- `req_val`  in  NFU x DW  per-FU result value.
- `hold`  in  1  CDB consumers stalled; suppresses granting.
- `grant`  out  NFU  one-hot grant, combinational; drives each FU's `cdb_transmit` input.
- `cdb_valid`  out  1  registered broadcast valid.
- `cdb_id`  out  IDW  registered broadcast tag.
- `cdb_val`  out  DW  registered broadcast value.
- `grant_cnt`  out  NFU x 16  per-FU grant counters; present only with `CDB_ARB_PERF_EN`.
- `conflict_cnt`  out  16  contended-cycle counter; present only with `CDB_ARB_PERF_EN`.

## Operation
- State: round-robin pointer `ptr`, width clog2(NFU); registered `cdb_valid`, `cdb_id` and `cdb_val`.
- Arbitration: search `req` starting at index `ptr` and wrapping modulo NFU. The first asserted index `w` wins.
- `grant[w]=1` when `hold=0` and any `req` is asserted. Otherwise `grant` is all zero.
- `grant` has at most one bit set in every cycle. `grant[i]` is never asserted while `req[i]=0`.
- On an edge with a grant to `w`:
  - `cdb_valid<=1`, `cdb_id<=req_id[w]`, `cdb_val<=req_val[w]`.
  - `ptr <= (w+1) mod NFU`, wrapping to 0 at the top index.
- On an edge with no grant (no requests, or `hold=1`): `cdb_valid<=0`. `cdb_id` and `cdb_val` keep their last values. `ptr` is unchanged.
- FU contract: `req_id`/`req_val` stay stable while `req` is high and ungranted. `req` may drop the cycle after a grant or stay high for the next result. The arbiter does not check this contract.
- Fairness: any continuously requesting FU is granted within NFU non-hold cycles.
- Reset values (asynchronous, immediate): `ptr=0`, `cdb_valid=0`, `cdb_id=0`, `cdb_val=0`, all counters 0. While `rst=1`, `grant` is forced to 0.
- Reset mid-operation: an in-flight broadcast is dropped. After release, arbitration restarts from FU 0.

## Timing
- Grant latency: `grant` is asserted in the same cycle as `req` when `hold=0`, with zero latency.
- Broadcast latency: `cdb_valid` is high in the cycle after the grant cycle, for exactly one cycle per grant.
- Throughput: one broadcast per cycle. A single FU requesting continuously is granted back-to-back.
- `hold` is sampled combinationally. `hold=1` in cycle N means no grant in cycle N and `cdb_valid=0` in cycle N+1. The broadcast already registered in cycle N stays visible during cycle N.
- Combinational path: `req`/`hold` to `grant` passes through the NFU-wide priority rotate only. There is no path from `req_val` to `grant`.

## Configuration
- `CDB_ARB_PERF_EN` defined:
  - `grant_cnt[i]` increments on each edge where `grant[i]=1`. It saturates at 16'hFFFF.
  - `conflict_cnt` increments on each edge with a grant and two or more `req` bits set. It saturates at 16'hFFFF.
  - Both are cleared only by `rst`.
- `CDB_ARB_PERF_EN` undefined: the counter ports and logic are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Reset: assert `rst` mid-broadcast -> `cdb_valid`, `cdb_id` and `cdb_val` go to 0 immediately and `grant=0`. After release, `req=4'b1111` -> first grant is 4'b0001.
- Round-robin: `req=4'b1111` held 8 cycles -> `grant` sequence is 0001, 0010, 0100, 1000, 0001, ... and `cdb_id` follows each FU's tag one cycle later.
- Wrap/skip: with `ptr=3`, `req=4'b0101` -> grant 0001; next cycle, same `req` -> grant 0100. `cdb_val` shows FU0's value, then FU2's value on consecutive cycles.
- Hold: `req=4'b0010` with `hold=1` for 3 cycles -> `grant=0` and `cdb_valid=0` throughout. Drop `hold` -> grant 0010, and `cdb_valid=1` next cycle with FU1's tag/value (e.g. id 4'hA, val 8'h5C).
- Single requester streaming: `req=4'b1000` for 5 cycles -> grant every cycle and `cdb_valid` high for 5 consecutive cycles.
- Perf (`CDB_ARB_PERF_EN`): 6 cycles with `req=4'b0011` -> `grant_cnt[0]=3`, `grant_cnt[1]=3`, `conflict_cnt=6`. Force a counter to 16'hFFFF and grant once more -> it stays at 16'hFFFF.
